// File: rtl/ras_ctrl.sv
// Return-address-stack controller for the fetch stage.
// Holds a circular speculative return stack written by the fetch decoder.
// A committed pointer/count pair, advanced by retire, repairs the speculative
// pointer/count on a pipeline flush. Stack contents are never repaired.
module ras_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        upd_vld_i,
  input  logic [1:0]  ras_ctrl_i,
  input  logic [63:0] ras_pc_i,
  input  logic        cmt_vld_i,
  input  logic [1:0]  cmt_ctrl_i,
  input  logic        flush_vld_i,
  output logic [63:0] ras_data_o,
  output logic        ras_vld_o,
  output logic        ras_ovf_o,
  output logic        ras_udf_o
);

  localparam logic [1:0]  CMD_NONE = 2'b00;
  localparam logic [1:0]  CMD_PUSH = 2'b01;
  localparam logic [1:0]  CMD_POP  = 2'b10;
  localparam logic [1:0]  CMD_PP   = 2'b11;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] TOS_ONE  = AW'(1);
  localparam logic [AW-1:0] TOS_ZERO = AW'(0);

  // Top-of-stack after a command; pointer wraps naturally at AW bits.
  function automatic logic [AW-1:0] next_tos(input logic [1:0]    cmd,
                                             input logic [AW-1:0] tos,
                                             input logic [AW:0]   cnt);
    logic [AW-1:0] res;
    case (cmd)
      CMD_PUSH: res = tos + TOS_ONE;
      CMD_POP: begin
        if (cnt != CNT_ZERO) res = tos - TOS_ONE;
        else                 res = tos;
      end
      CMD_PP:   res = tos;
      CMD_NONE: res = tos;
      default:  res = tos;
    endcase
    return res;
  endfunction

  // Occupancy after a command; saturates at DEPTH and never drops below 0.
  function automatic logic [AW:0] next_cnt(input logic [1:0] cmd,
                                           input logic [AW:0] cnt);
    logic [AW:0] res;
    case (cmd)
      CMD_PUSH: begin
        if (cnt == CNT_FULL) res = cnt;
        else                 res = cnt + CNT_ONE;
      end
      CMD_POP: begin
        if (cnt != CNT_ZERO) res = cnt - CNT_ONE;
        else                 res = cnt;
      end
      CMD_PP: begin
        if (cnt == CNT_ZERO) res = CNT_ONE;
        else                 res = cnt;
      end
      CMD_NONE: res = cnt;
      default:  res = cnt;
    endcase
    return res;
  endfunction

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] spec_tos_r;
  logic [AW:0]   spec_cnt_r;
  logic [AW-1:0] cmt_tos_r;
  logic [AW:0]   cmt_cnt_r;
  logic          ovf_r;
  logic          udf_r;

  logic [AW-1:0] cmt_tos_nxt_s;
  logic [AW:0]   cmt_cnt_nxt_s;
  logic [AW-1:0] spec_tos_nxt_s;
  logic [AW:0]   spec_cnt_nxt_s;
  logic          upd_act_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;
  logic [63:0]   push_val_s;
  logic          ovf_nxt_s;
  logic          udf_nxt_s;

  assign push_val_s = ras_pc_i + 64'd4;
  // A flush squashes whatever the decoder is presenting this cycle.
  assign upd_act_s  = upd_vld_i & ~flush_vld_i;

  // Committed pointer/count advance on every retire strobe, flush or not.
  always_comb begin
    cmt_tos_nxt_s = cmt_tos_r;
    cmt_cnt_nxt_s = cmt_cnt_r;
    if (cmt_vld_i) begin
      cmt_tos_nxt_s = next_tos(cmt_ctrl_i, cmt_tos_r, cmt_cnt_r);
      cmt_cnt_nxt_s = next_cnt(cmt_ctrl_i, cmt_cnt_r);
    end else begin
      cmt_tos_nxt_s = cmt_tos_r;
      cmt_cnt_nxt_s = cmt_cnt_r;
    end
  end

  // Speculative pointer/count: flush restores from the post-retire committed
  // state, otherwise the fetch command is applied.
  always_comb begin
    spec_tos_nxt_s = spec_tos_r;
    spec_cnt_nxt_s = spec_cnt_r;
    if (flush_vld_i) begin
      spec_tos_nxt_s = cmt_tos_nxt_s;
      spec_cnt_nxt_s = cmt_cnt_nxt_s;
    end else if (upd_vld_i) begin
      spec_tos_nxt_s = next_tos(ras_ctrl_i, spec_tos_r, spec_cnt_r);
      spec_cnt_nxt_s = next_cnt(ras_ctrl_i, spec_cnt_r);
    end else begin
      spec_tos_nxt_s = spec_tos_r;
      spec_cnt_nxt_s = spec_cnt_r;
    end
  end

  // Stack write and event flags for the fetch command.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = TOS_ZERO;
    ovf_nxt_s   = 1'b0;
    udf_nxt_s   = 1'b0;
    if (upd_act_s) begin
      case (ras_ctrl_i)
        CMD_PUSH: begin
          mem_we_s    = 1'b1;
          mem_waddr_s = spec_tos_r + TOS_ONE;
          ovf_nxt_s   = (spec_cnt_r == CNT_FULL);
        end
        CMD_POP: begin
          udf_nxt_s = (spec_cnt_r == CNT_ZERO);
        end
        CMD_PP: begin
          // Coroutine swap: replace the top in place, never flags.
          mem_we_s    = 1'b1;
          mem_waddr_s = spec_tos_r;
        end
        CMD_NONE: begin
          mem_we_s = 1'b0;
        end
        default: begin
          mem_we_s = 1'b0;
        end
      endcase
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
      spec_tos_r <= TOS_ZERO;
      spec_cnt_r <= CNT_ZERO;
      cmt_tos_r  <= TOS_ZERO;
      cmt_cnt_r  <= CNT_ZERO;
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
    end else begin
      if (mem_we_s) begin
        mem_r[mem_waddr_s] <= push_val_s;
      end
      spec_tos_r <= spec_tos_nxt_s;
      spec_cnt_r <= spec_cnt_nxt_s;
      cmt_tos_r  <= cmt_tos_nxt_s;
      cmt_cnt_r  <= cmt_cnt_nxt_s;
      ovf_r      <= ovf_nxt_s;
      udf_r      <= udf_nxt_s;
    end
  end

  // Prediction is read straight from the stack so the decoder sees it with
  // no extra latency.
  assign ras_data_o = mem_r[spec_tos_r];
  assign ras_vld_o  = (spec_cnt_r != CNT_ZERO);
  assign ras_ovf_o  = ovf_r;
  assign ras_udf_o  = udf_r;

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed scenarios plus random traffic,
// checked against a stack model through an expected-response queue.
module tb_ras_ctrl;

  localparam int D = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        upd_vld_i = 1'b0;
  logic [1:0]  ras_ctrl_i = 2'b00;
  logic [63:0] ras_pc_i = 64'd0;
  logic        cmt_vld_i = 1'b0;
  logic [1:0]  cmt_ctrl_i = 2'b00;
  logic        flush_vld_i = 1'b0;
  logic [63:0] ras_data_o;
  logic        ras_vld_o;
  logic        ras_ovf_o;
  logic        ras_udf_o;

  ras_ctrl #(.DEPTH(D), .AW(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .upd_vld_i(upd_vld_i),
    .ras_ctrl_i(ras_ctrl_i), .ras_pc_i(ras_pc_i), .cmt_vld_i(cmt_vld_i),
    .cmt_ctrl_i(cmt_ctrl_i), .flush_vld_i(flush_vld_i),
    .ras_data_o(ras_data_o), .ras_vld_o(ras_vld_o),
    .ras_ovf_o(ras_ovf_o), .ras_udf_o(ras_udf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] data;
    logic        vld;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: a circular array with integer pointers.
  logic [63:0] m [D];
  int st, sc, ct, cc;
  logic mo, mu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: the DUT presents a new response every cycle.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data", ras_data_o, e.data);
      chk("vld", {63'd0, ras_vld_o}, {63'd0, e.vld});
      chk("ovf", {63'd0, ras_ovf_o}, {63'd0, e.ovf});
      chk("udf", {63'd0, ras_udf_o}, {63'd0, e.udf});
    end
  end

  task automatic model_cmd(input logic [1:0] cmd, inout int t, inout int c);
    if (cmd == 2'b01) begin
      t = (t + 1) % D;
      if (c < D) c++;
    end else if (cmd == 2'b10) begin
      if (c > 0) begin
        t = (t + D - 1) % D;
        c--;
      end
    end else if (cmd == 2'b11) begin
      if (c == 0) c = 1;
    end
  endtask

  task automatic cyc(input logic rst, input logic up, input logic [1:0] cmd,
                     input logic [63:0] pc, input logic cv, input logic [1:0] ccmd,
                     input logic fl);
    @(negedge clk_i);
    rst_n_i = rst; upd_vld_i = up; ras_ctrl_i = cmd; ras_pc_i = pc;
    cmt_vld_i = cv; cmt_ctrl_i = ccmd; flush_vld_i = fl;
    mo = 1'b0; mu = 1'b0;
    if (!rst) begin
      for (int i = 0; i < D; i++) m[i] = 64'd0;
      st = 0; sc = 0; ct = 0; cc = 0;
    end else begin
      if (cv) model_cmd(ccmd, ct, cc);
      if (fl) begin
        st = ct; sc = cc;
      end else if (up) begin
        if (cmd == 2'b01) begin
          mo = (sc == D);
          m[(st + 1) % D] = pc + 64'd4;
        end else if (cmd == 2'b10) begin
          mu = (sc == 0);
        end else if (cmd == 2'b11) begin
          m[st] = pc + 64'd4;
        end
        model_cmd(cmd, st, sc);
      end
    end
    exp_q.push_back('{m[st], (sc != 0), mo, mu});
  endtask

  task automatic f(input logic [1:0] cmd, input logic [63:0] pc);
    cyc(1'b1, 1'b1, cmd, pc, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 2'b00, 64'd0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic rst2();
    cyc(1'b0, 1'b0, 2'b00, 64'd0, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 64'd0, 1'b0, 2'b00, 1'b0);
  endtask

  // Direct check of the outputs after the cycle just issued takes effect.
  task automatic dchk(input string name, input logic [63:0] data, input logic vld,
                      input logic ovf, input logic udf);
    @(posedge clk_i);
    #2;
    chk({name, "_data"}, ras_data_o, data);
    chk({name, "_vld"}, {63'd0, ras_vld_o}, {63'd0, vld});
    chk({name, "_flags"}, {62'd0, ras_ovf_o, ras_udf_o}, {62'd0, ovf, udf});
  endtask

  initial begin
    // Reset, basic push/pop, underflow.
    rst2();
    dchk("reset", 64'd0, 1'b0, 1'b0, 1'b0);
    f(2'b01, 64'h1000); f(2'b01, 64'h2000); f(2'b01, 64'h3000);
    dchk("push3", 64'h3004, 1'b1, 1'b0, 1'b0);
    f(2'b10, 64'd0); f(2'b10, 64'd0);
    dchk("pop2", 64'h1004, 1'b1, 1'b0, 1'b0);
    f(2'b10, 64'd0);
    dchk("pop3", 64'd0, 1'b0, 1'b0, 1'b0);
    f(2'b10, 64'd0);
    dchk("udf", 64'd0, 1'b0, 1'b0, 1'b1);
    idle();
    dchk("udf_end", 64'd0, 1'b0, 1'b0, 1'b0);

    // Overflow wrap at DEPTH = 8.
    rst2();
    for (int i = 1; i <= 9; i++) f(2'b01, 64'(i * 256));
    dchk("ovf", 64'h904, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) f(2'b10, 64'd0);
    dchk("ovf_pop7", 64'h204, 1'b1, 1'b0, 1'b0);
    f(2'b10, 64'd0);
    dchk("ovf_pop8", 64'h904, 1'b0, 1'b0, 1'b0);

    // Coroutine.
    rst2();
    f(2'b01, 64'h40);
    f(2'b11, 64'h80);
    dchk("coro", 64'h84, 1'b1, 1'b0, 1'b0);
    f(2'b10, 64'd0);
    dchk("coro_pop", 64'd0, 1'b0, 1'b0, 1'b0);
    f(2'b11, 64'h500);
    dchk("coro_empty", 64'h504, 1'b1, 1'b0, 1'b0);

    // Speculative repair.
    rst2();
    cyc(1'b1, 1'b1, 2'b01, 64'hA00, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b1, 2'b01, 64'hB00, 1'b1, 2'b01, 1'b0);
    f(2'b01, 64'hC00);
    f(2'b10, 64'd0);
    f(2'b10, 64'd0);
    cyc(1'b1, 1'b0, 2'b00, 64'd0, 1'b0, 2'b00, 1'b1);
    dchk("repair", 64'hB04, 1'b1, 1'b0, 1'b0);

    // Flush + fetch push + retire pop together.
    cyc(1'b1, 1'b1, 2'b01, 64'hD00, 1'b1, 2'b10, 1'b1);
    dchk("flush_mix", 64'hA04, 1'b1, 1'b0, 1'b0);

    // Reset over flush and push, then normal operation.
    cyc(1'b0, 1'b1, 2'b01, 64'hE00, 1'b1, 2'b01, 1'b1);
    dchk("rst_mid", 64'd0, 1'b0, 1'b0, 1'b0);
    f(2'b01, 64'h700);
    dchk("post_rst", 64'h704, 1'b1, 1'b0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)), {32'($urandom), 32'($urandom)},
          ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0));
    end

    idle();
    repeat (3) @(negedge clk_i);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Return-address-stack controller for the fetch stage.
- Consumes the per-bundle RAS command and branch PC produced by the fetch branch decoder, and maintains a circular speculative return stack.
- Drives the predicted return target back to the decoder.
- Keeps a committed pointer/count, updated from retire, to repair the speculative stack on pipeline flush.

Parameters:
- DEPTH, 8, number of stack entries; must be a power of 2, at least 2.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk_i  input  1  core clock
- rst_n_i  input  1  synchronous active-low reset
- upd_vld_i  input  1  fetch-side update strobe; tie to the decoder's BTB write enable
- ras_ctrl_i  input  2  fetch-side command: 00 none, 01 push, 10 pop, 11 pop-then-push (coroutine)
- ras_pc_i  input  64  PC of the call/return instruction in the bundle
- cmt_vld_i  input  1  retire-side update strobe
- cmt_ctrl_i  input  2  retire-side command, same encoding as ras_ctrl_i
- flush_vld_i  input  1  pipeline flush/redirect
- ras_data_o  output  64  predicted return address; equals mem[spec_tos]
- ras_vld_o  output  1  speculative count is nonzero
- ras_ovf_o  output  1  one-cycle pulse: a push was accepted while count == DEPTH
- ras_udf_o  output  1  one-cycle pulse: a pop was accepted while count == 0

Behaviour:
- State:
  - mem[DEPTH] x 64.
  - spec_tos and cmt_tos: AW bits each; point at the top valid entry.
  - spec_cnt and cmt_cnt: AW+1 bits each, range 0..DEPTH.
- Reset (rst_n_i low at a clock edge): all mem entries 0, both tos 0, both cnt 0, ras_ovf_o 0, ras_udf_o 0. Therefore ras_data_o = 0 and ras_vld_o = 0.
- ras_data_o and ras_vld_o are combinational from registered state, with zero latency into the decoder. A command takes effect in the cycle after its strobe.
- Push value is always ras_pc_i + 64'd4, with 64-bit wrap.
- Fetch-side update, applied when upd_vld_i = 1 and flush_vld_i = 0:
  - push: spec_tos <= spec_tos + 1 (mod DEPTH); mem[spec_tos + 1] <= push value; spec_cnt <= min(spec_cnt + 1, DEPTH).
  - Push when full: the oldest entry is silently overwritten by the wrap, spec_cnt stays DEPTH, ras_ovf_o pulses.
  - pop with spec_cnt > 0: spec_tos <= spec_tos - 1 (mod DEPTH); spec_cnt <= spec_cnt - 1.
  - pop with spec_cnt == 0: no pointer or count change; ras_udf_o pulses.
  - pop-then-push: mem[spec_tos] <= push value; spec_tos unchanged; spec_cnt <= max(spec_cnt, 1). No ovf or udf pulse.
  - none: no change.
- Retire-side update, applied when cmt_vld_i = 1: same pointer/count arithmetic on cmt_tos/cmt_cnt, with no memory write and no flag pulses. It is applied regardless of flush_vld_i.
- Flush (flush_vld_i = 1):
  - spec_tos <= next cmt_tos and spec_cnt <= next cmt_cnt, i.e. the values after any same-cycle retire update.
  - Any same-cycle fetch-side update is dropped; no mem write, no flags.
  - mem is not repaired. Entries overwritten by squashed speculative pushes stay corrupt; this is an accepted mispredict source.
- Flags (ras_ovf_o, ras_udf_o) are registered and high for exactly one cycle per event. Both are 0 in any cycle following a flush.
- upd_vld_i with ras_ctrl_i = 00 is legal and is a no-op.
- Reset asserted mid-stream has priority over flush and over all updates.
- Pointer arithmetic is modulo DEPTH via natural AW-bit wrap; no divider is used.

Test Plan:
- Reset, then three pushes with ras_pc_i = 0x1000, 0x2000, 0x3000 -> ras_data_o = 0x3004, ras_vld_o = 1, spec_cnt = 3. Then two pops -> ras_data_o = 0x1004. A third pop -> ras_vld_o = 0. A fourth pop -> ras_udf_o pulses for 1 cycle and state is unchanged.
- DEPTH = 8: nine pushes with PCs 0x100..0x900 (step 0x100) -> ras_ovf_o pulses on the 9th only, spec_cnt = 8, ras_data_o = 0x904. Eight pops then return 0x904 down to 0x204; the entry for 0x104 is lost.
- Coroutine: push 0x40, then pop-then-push with ras_pc_i = 0x80 -> ras_data_o = 0x84, count still 1. Pop-then-push on an empty stack -> count becomes 1, no udf pulse.
- Speculative repair: retire pushes 0xA00 and 0xB00 in step with fetch; fetch then pushes 0xC00 speculatively and pops twice; then flush -> spec_cnt = 2 and ras_data_o = mem at cmt_tos.
- Simultaneous events: flush, a fetch push and a retire pop in the same cycle -> fetch push dropped, spec_cnt = cmt_cnt - 1, no mem write observed.
- Reset mid-operation: assert rst_n_i low while a flush and a push are active -> all outputs 0 next cycle. Normal pushes work immediately after release.
